// File: rtl/pipe_ctrl.sv
// Central pipeline controller: merges ID/EX stall requests into a per-stage
// stall vector, sequences exception flush/redirect, counts stall cycles and
// halts the core when an EX stall never releases.
module pipe_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             excp_req,
  input  logic [31:0]      excp_pc,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             stall_timeout
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2,
    HALT     = 2'd3
  } state_t;

  localparam logic [7:0]       WD_LAST = 8'(TIMEOUT - 1);
  localparam logic [5:0]       STALL_EX  = 6'b001111;
  localparam logic [5:0]       STALL_ID  = 6'b000111;
  localparam logic [5:0]       STALL_ALL = 6'b111111;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t     state, state_nxt;
  logic [7:0] wd_cnt, wd_nxt;
  logic       latch_pc;
  logic       trip;

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_nxt = state;
    wd_nxt    = wd_cnt;
    stall     = '0;
    latch_pc  = 1'b0;
    trip      = 1'b0;
    case (state)
      RUN: begin
        if (excp_req) begin
          latch_pc  = 1'b1;
          wd_nxt    = '0;
          state_nxt = FLUSH;
        end else if (stallreq_ex) begin
          stall  = STALL_EX;
          wd_nxt = wd_cnt + 8'd1;
          if (wd_cnt == WD_LAST) begin
            trip      = 1'b1;
            state_nxt = HALT;
          end
        end else if (stallreq_id) begin
          stall  = STALL_ID;
          wd_nxt = '0;
        end else begin
          wd_nxt = '0;
        end
      end
      // Pipeline contents are stale during FLUSH/REDIRECT: all requests ignored.
      FLUSH:    state_nxt = REDIRECT;
      REDIRECT: state_nxt = RUN;
      HALT:     stall     = STALL_ALL;
      default:  state_nxt = RUN;
    endcase
    if (rst) stall = '0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      wd_cnt        <= '0;
      new_pc        <= '0;
      stall_cnt     <= '0;
      stall_timeout <= 1'b0;
    end else begin
      state  <= state_nxt;
      wd_cnt <= wd_nxt;
      if (latch_pc) new_pc <= excp_pc;
      if (trip) stall_timeout <= 1'b1;
      // Saturate rather than wrap so a long HALT never reads as few stalls.
      if (stall[0] && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

  assign flush      = (state == FLUSH);
  assign ctrl_state = state;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios then randomized
// traffic, all compared against a behavioural reference model.
module tb_pipe_ctrl;

  localparam int unsigned TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst, stallreq_id, stallreq_ex, excp_req;
  logic [31:0] excp_pc;
  logic [5:0]  stall, stall_s;
  logic        flush, flush_s;
  logic [31:0] new_pc, new_pc_s;
  logic [1:0]  ctrl_state, ctrl_state_s;
  logic [31:0] stall_cnt;
  logic [3:0]  stall_cnt_s;
  logic        stall_timeout, stall_timeout_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
    .excp_req(excp_req), .excp_pc(excp_pc), .stall(stall), .flush(flush),
    .new_pc(new_pc), .ctrl_state(ctrl_state), .stall_cnt(stall_cnt),
    .stall_timeout(stall_timeout)
  );

  // Narrow-counter instance shares stimulus to exercise saturation.
  pipe_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
    .excp_req(excp_req), .excp_pc(excp_pc), .stall(stall_s), .flush(flush_s),
    .new_pc(new_pc_s), .ctrl_state(ctrl_state_s), .stall_cnt(stall_cnt_s),
    .stall_timeout(stall_timeout_s)
  );

  // Reference model: phase number, length of current EX-stall streak,
  // unbounded stall-cycle tally.
  int          m_phase;
  int          m_streak;
  longint      m_cnt;
  logic [31:0] m_pc;
  logic        m_to;
  bit          m_valid = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [5:0] exp_stall(input logic r, input logic id, input logic ex,
                                           input logic ereq);
    if (r) return 6'd0;
    if (m_phase == 3) return 6'b111111;
    if (m_phase != 0 || ereq) return 6'd0;
    if (ex) return 6'b001111;
    if (id) return 6'b000111;
    return 6'd0;
  endfunction

  task automatic cycle(input logic r, input logic id, input logic ex, input logic ereq,
                       input logic [31:0] pc);
    logic [5:0] es;
    @(negedge clk);
    rst = r; stallreq_id = id; stallreq_ex = ex; excp_req = ereq; excp_pc = pc;
    #1;
    es = exp_stall(r, id, ex, ereq);
    check("stall", 64'(stall), 64'(es));
    check("stall_s", 64'(stall_s), 64'(es));
    if (m_valid) begin
      check("ctrl_state", 64'(ctrl_state), 64'(m_phase));
      check("flush", 64'(flush), 64'(m_phase == 1));
      check("new_pc", 64'(new_pc), 64'(m_pc));
      check("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
      check("stall_cnt_sat", 64'(stall_cnt_s), 64'((m_cnt > 15) ? 15 : m_cnt));
      check("stall_timeout", 64'(stall_timeout), 64'(m_to));
    end
    @(posedge clk);
    #1;
    if (r) begin
      m_phase = 0; m_streak = 0; m_cnt = 0; m_pc = '0; m_to = 1'b0; m_valid = 1'b1;
    end else begin
      if (es[0]) m_cnt++;
      case (m_phase)
        0: begin
          if (ereq) begin
            m_pc = pc; m_streak = 0; m_phase = 1;
          end else if (ex) begin
            m_streak++;
            if (m_streak == TIMEOUT) begin
              m_phase = 3; m_to = 1'b1;
            end
          end else begin
            m_streak = 0;
          end
        end
        1: m_phase = 2;
        2: m_phase = 0;
        default: ;
      endcase
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
  endtask

  initial begin
    int bias;
    logic r, id, ex, er;
    rst = 1'b1; stallreq_id = 1'b0; stallreq_ex = 1'b0; excp_req = 1'b0; excp_pc = '0;

    // Reset and idle
    do_reset();
    idle(5);
    check("idle_cnt", 64'(stall_cnt), 64'd0);
    check("idle_state", 64'(ctrl_state), 64'd0);

    // ID stalls, then combined ID+EX
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    check("id_cnt3", 64'(stall_cnt), 64'd3);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

    // Exception with concurrent EX stall; second exception during FLUSH dropped
    do_reset();
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0180);
    check("excp_flush", 64'(flush), 64'd1);
    check("excp_pc", 64'(new_pc), 64'h180);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
    check("redirect_state", 64'(ctrl_state), 64'd2);
    check("dropped_excp_pc", 64'(new_pc), 64'h180);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("back_to_run", 64'(ctrl_state), 64'd0);
    idle(2);

    // Watchdog trip, HALT ignores exceptions, reset recovers
    do_reset();
    for (int i = 0; i < TIMEOUT; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    check("halt_state", 64'(ctrl_state), 64'd3);
    check("halt_timeout", 64'(stall_timeout), 64'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'hdead_beef);
    check("halt_excp_ignored", 64'(ctrl_state), 64'd3);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check("rst_timeout", 64'(stall_timeout), 64'd0);
    check("rst_cnt", 64'(stall_cnt), 64'd0);
    idle(2);

    // 15 on, 1 off, 15 on: no trip
    do_reset();
    for (int i = 0; i < 15; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 15; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    check("no_trip_cnt", 64'(stall_cnt), 64'd30);
    check("no_trip_to", 64'(stall_timeout), 64'd0);

    // Trip and exception in the same cycle: exception wins
    do_reset();
    for (int i = 0; i < TIMEOUT - 1; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0080);
    check("trip_vs_excp_state", 64'(ctrl_state), 64'd1);
    check("trip_vs_excp_to", 64'(stall_timeout), 64'd0);
    idle(3);

    // Saturation of the narrow counter
    do_reset();
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    check("sat_cnt", 64'(stall_cnt_s), 64'hF);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    check("sat_hold", 64'(stall_cnt_s), 64'hF);

    // Randomized traffic
    do_reset();
    bias = 50;
    for (int i = 0; i < 4000; i++) begin
      if (i % 60 == 0) bias = ($urandom_range(0, 1) == 1) ? 97 : 50;
      r  = ($urandom_range(0, 199) == 0) || (m_phase == 3 && $urandom_range(0, 5) == 0);
      ex = ($urandom_range(0, 99) < bias);
      id = $urandom_range(0, 1) == 1;
      er = ($urandom_range(0, 99) < ((bias > 90) ? 2 : 8));
      cycle(r, id, ex, er, $urandom());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
